// File: rtl/fetch_queue.sv
// Fetch queue: buffers PC/fetch groups in a circular queue, presents them in order to decode, and stalls the PC when space runs low.
// Optional performance counters are enabled by defining FETCHQ_PERF_CNT_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned STALL_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [PC_W-1:0]          fetch_pc,
  input  logic [31:0]              fetch_instr0,
  input  logic [31:0]              fetch_instr1,
  input  logic                     fetch_instr1_valid,
  input  logic                     fetch_pred_taken0,
  output logic                     stall,
  input  logic                     dec_ready,
  output logic                     dec_valid0,
  output logic                     dec_valid1,
  output logic [PC_W-1:0]          dec_pc0,
  output logic [PC_W-1:0]          dec_pc1,
  output logic [31:0]              dec_instr0,
  output logic [31:0]              dec_instr1,
`ifdef FETCHQ_PERF_CNT_EN
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flush_cnt,
  output logic [31:0]              perf_drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] TH_L    = (AW+1)'(STALL_TH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [PC_W-1:0]  mem_pc [DEPTH];
  logic [31:0]      mem_i0 [DEPTH];
  logic [31:0]      mem_i1 [DEPTH];
  logic             mem_v1 [DEPTH];

  logic             empty, full, push, pop;
  logic [AW:0]      free_cnt;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_L);
  assign free_cnt = DEPTH_L - count;
  assign stall    = (free_cnt <= TH_L);

  assign push = fetch_valid && !full && !flush;
  assign pop  = dec_ready && !empty && !flush;

  // Pointer registers; on flush the write pointer collapses onto the read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage is never cleared; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_pc[wr_idx] <= fetch_pc;
      mem_i0[wr_idx] <= fetch_instr0;
      mem_i1[wr_idx] <= fetch_instr1;
      mem_v1[wr_idx] <= fetch_instr1_valid && !fetch_pred_taken0;
    end
  end

  always_comb begin
    dec_valid0 = !empty && !flush;
    dec_valid1 = dec_valid0 && mem_v1[rd_idx];
    dec_pc0    = mem_pc[rd_idx];
    dec_pc1    = mem_pc[rd_idx] + PC_W'(4);
    dec_instr0 = mem_i0[rd_idx];
    dec_instr1 = mem_i1[rd_idx];
  end

`ifdef FETCHQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
      perf_drop_cnt     <= '0;
    end else begin
      if (stall && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (flush && perf_flush_cnt != '1)    perf_flush_cnt    <= perf_flush_cnt + 1'b1;
      if (fetch_valid && full && !flush && perf_drop_cnt != '1)
        perf_drop_cnt <= perf_drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected head groups, a negedge monitor checks every group decode accepts.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_instr1_valid, fetch_pred_taken0, dec_ready;
  logic [31:0] fetch_pc, fetch_instr0, fetch_instr1;
  logic        stall, dec_valid0, dec_valid1;
  logic [31:0] dec_pc0, dec_pc1, dec_instr0, dec_instr1;
  logic [3:0]  count;
`ifdef FETCHQ_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_cnt, perf_drop_cnt;
`endif

  fetch_queue #(.DEPTH(8), .PC_W(32), .STALL_TH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
    .fetch_instr1_valid(fetch_instr1_valid), .fetch_pred_taken0(fetch_pred_taken0),
    .stall(stall), .dec_ready(dec_ready),
    .dec_valid0(dec_valid0), .dec_valid1(dec_valid1),
    .dec_pc0(dec_pc0), .dec_pc1(dec_pc1),
    .dec_instr0(dec_instr0), .dec_instr1(dec_instr1),
`ifdef FETCHQ_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_cnt(perf_flush_cnt),
    .perf_drop_cnt(perf_drop_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        v1;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every group decode accepts must match the oldest expected group.
  always @(negedge clk) begin
    if (started && dec_valid0 === 1'b1 && dec_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_unexpected: got pc0=%0h, required no valid head", dec_pc0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_pc0", 64'(dec_pc0), 64'(e.pc));
        chk("mon_pc1", 64'(dec_pc1), 64'(e.pc + 32'd4));
        chk("mon_instr0", 64'(dec_instr0), 64'(e.i0));
        chk("mon_valid1", 64'(dec_valid1), 64'(e.v1));
        if (e.v1) chk("mon_instr1", 64'(dec_instr1), 64'(e.i1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                       input bit v1, input bit pt, input bit acc);
    exp_t e;
    fetch_valid        = 1'b1;
    fetch_pc           = pc;
    fetch_instr0       = i0;
    fetch_instr1       = i1;
    fetch_instr1_valid = v1;
    fetch_pred_taken0  = pt;
    if (acc) begin
      e.pc = pc; e.i0 = i0; e.i1 = i1; e.v1 = v1 && !pt;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    fetch_valid        = 1'b0;
    fetch_instr1_valid = 1'b0;
    fetch_pred_taken0  = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    fetch_pc = '0; fetch_instr0 = '0; fetch_instr1 = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_valid0", 64'(dec_valid0), 64'd0);

    // Basic flow, including absence of same-cycle bypass.
    tick();
    dec_ready = 1'b1;
    drive(32'h1000, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("basic_no_bypass", 64'(dec_valid0), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("basic_valid0", 64'(dec_valid0), 64'd1);
    chk("basic_valid1", 64'(dec_valid1), 64'd1);
    chk("basic_pc0", 64'(dec_pc0), 64'h1000);
    chk("basic_pc1", 64'(dec_pc1), 64'h1004);
    tick();
    @(negedge clk);
    chk("basic_empty_valid0", 64'(dec_valid0), 64'd0);
    chk("basic_empty_count", 64'(count), 64'd0);

    // Line crossing and predicted-taken slot squash.
    tick();
    dec_ready = 1'b0;
    drive(32'h101C, 32'hAAAA_0001, 32'hBBBB_0001, 1'b0, 1'b0, 1'b1);
    tick();
    drive(32'h2000, 32'hAAAA_0002, 32'hBBBB_0002, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("lx_count", 64'(count), 64'd2);
    chk("lx_head_valid1", 64'(dec_valid1), 64'd0);
    tick();
    dec_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("pt_head_pc0", 64'(dec_pc0), 64'h2000);
    chk("pt_head_valid1", 64'(dec_valid1), 64'd0);
    tick();
    dec_ready = 1'b0;
    @(negedge clk);
    chk("lx_drained", 64'(count), 64'd0);

    // Fill to full with stall threshold, then one dropped group.
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      drive(32'h4000 + 32'(8 * i), 32'h1100_0000 + 32'(i), 32'h2200_0000 + 32'(i),
            1'b1, 1'b0, cnt < 8);
      @(negedge clk);
      chk("fill_count", 64'(count), 64'(cnt));
      chk("fill_stall", 64'(stall), 64'((8 - cnt) <= 2));
      if (cnt < 8) cnt++;
    end
    tick();
    idle();
    @(negedge clk);
    chk("full_count", 64'(count), 64'd8);
    chk("full_stall", 64'(stall), 64'd1);
    tick();
    dec_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("fill_drained_count", 64'(count), 64'd0);
    chk("fill_drained_valid0", 64'(dec_valid0), 64'd0);

    // Wrap-around with simultaneous push and pop.
    for (int i = 0; i < 20; i++) begin
      tick();
      drive(32'(8 * i), 32'h3300_0000 + 32'(i), 32'h4400_0000 + 32'(i), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("wrap_count_le1", 64'(count <= 4'd1), 64'd1);
    end
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("wrap_drained", 64'(count), 64'd0);

    // Flush with 5 entries held, push and pop requested in the flush cycle.
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(32'h5000 + 32'(8 * i), 32'h5500_0000 + 32'(i), 32'h6600_0000 + 32'(i),
            1'b1, 1'b0, 1'b1);
    end
    tick();
    idle();
    @(negedge clk);
    chk("preflush_count", 64'(count), 64'd5);
    tick();
    exp_q.delete();
    flush = 1'b1;
    dec_ready = 1'b1;
    drive(32'hDEAD_0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_valid0", 64'(dec_valid0), 64'd0);
    tick();
    flush = 1'b0;
    drive(32'h3000, 32'h7700_0001, 32'h8800_0001, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("postflush_count", 64'(count), 64'd0);
    chk("postflush_stall", 64'(stall), 64'd0);
    chk("postflush_valid0", 64'(dec_valid0), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("redirect_valid0", 64'(dec_valid0), 64'd1);
    chk("redirect_pc0", 64'(dec_pc0), 64'h3000);
    tick();
    @(negedge clk);
    chk("redirect_drained", 64'(count), 64'd0);

    // Reset with 4 entries queued.
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(32'h6000 + 32'(8 * i), 32'h9900_0000 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    idle();
    @(negedge clk);
    chk("prereset_count", 64'(count), 64'd4);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_stall", 64'(stall), 64'd0);
    chk("midreset_valid0", 64'(dec_valid0), 64'd0);
`ifdef FETCHQ_PERF_CNT_EN
    chk("midreset_perf_stall", 64'(perf_stall_cycles), 64'd0);
    chk("midreset_perf_flush", 64'(perf_flush_cnt), 64'd0);
    chk("midreset_perf_drop", 64'(perf_drop_cnt), 64'd0);
`endif
    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
